// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner for a 3-input combinational circuit: drives all
// eight {a,b,c} vectors (2 cycles each) and captures f_in. Optional compare: SCAN_COMPARE_EN.
module truth_table_scanner (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       f_in,
`ifdef SCAN_COMPARE_EN
   input  logic [7:0] expected,
   output logic       match,
`endif
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state_reg;
   logic [2:0] idx_reg;
   logic [7:0] capture_reg;
`ifdef SCAN_COMPARE_EN
   logic [7:0] expected_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         idx_reg     <= 3'd0;
         capture_reg <= 8'h00;
         {a, b, c}   <= 3'b000;
         busy        <= 1'b0;
         done        <= 1'b0;
         table_out   <= 8'h00;
`ifdef SCAN_COMPARE_EN
         expected_reg <= 8'h00;
         match        <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               {a, b, c} <= 3'b000;
               busy      <= 1'b0;
               done      <= 1'b0;
               if (start) begin
                  state_reg   <= DRIVE;
                  idx_reg     <= 3'd0;
                  capture_reg <= 8'h00;
                  busy        <= 1'b1;
`ifdef SCAN_COMPARE_EN
                  expected_reg <= expected;
`endif
               end
            end

            // One full cycle for the circuit under test to settle on the new vector.
            DRIVE: begin
               state_reg <= SAMPLE;
            end

            SAMPLE: begin
               capture_reg[idx_reg] <= f_in;
               if (idx_reg == 3'd7) begin
                  // Bit 7 is still in flight in capture_reg, so merge it in directly.
                  state_reg <= DONE;
                  table_out <= {f_in, capture_reg[6:0]};
                  {a, b, c} <= 3'b000;
                  busy      <= 1'b0;
                  done      <= 1'b1;
`ifdef SCAN_COMPARE_EN
                  match     <= ({f_in, capture_reg[6:0]} == expected_reg);
`endif
               end else begin
                  state_reg <= DRIVE;
                  idx_reg   <= idx_reg + 3'd1;
                  {a, b, c} <= idx_reg + 3'd1;
               end
            end

            DONE: begin
               state_reg <= IDLE;
               idx_reg   <= 3'd0;
               done      <= 1'b0;
               {a, b, c} <= 3'b000;
               busy      <= 1'b0;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: scans queue expected tables, a
// done-triggered monitor pops and compares them against table_out (and match).
module tb_truth_table_scanner;

   localparam int M_AND  = 0;
   localparam int M_XOR  = 1;
   localparam int M_ZERO = 2;
   localparam int M_ONE  = 3;
   localparam int M_LUT  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       f_in;
   logic       a, b, c;
   logic       busy, done;
   logic [7:0] table_out;
   logic [7:0] expected;
   logic       match;

   int         mode;
   logic [7:0] lut;
   logic       glitch;
   logic       f_core;

   int         n_checks = 0;
   int         n_fail   = 0;

   logic [7:0] sb_tab[$];
   logic       sb_match[$];

   always #5 clk = ~clk;

   truth_table_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .f_in      (f_in),
`ifdef SCAN_COMPARE_EN
      .expected  (expected),
      .match     (match),
`endif
      .a         (a),
      .b         (b),
      .c         (c),
      .busy      (busy),
      .done      (done),
      .table_out (table_out)
   );

`ifndef SCAN_COMPARE_EN
   assign match = 1'b0;
`endif

   // Circuit under test, with an optional glitch overlay during settle cycles.
   always_comb begin
      f_core = 1'b0;
      case (mode)
         M_AND:   f_core = a & b & c;
         M_XOR:   f_core = a ^ b ^ c;
         M_ZERO:  f_core = 1'b0;
         M_ONE:   f_core = 1'b1;
         default: f_core = lut[{a, b, c}];
      endcase
      f_in = f_core ^ glitch;
   end

   function automatic logic [7:0] model_table(input int md, input logic [7:0] lt);
      logic [7:0] t;
      t = 8'h00;
      for (int i = 0; i < 8; i++) begin
         int x, y, z;
         x = i / 4;
         y = (i / 2) % 2;
         z = i % 2;
         case (md)
            M_AND:   t[i] = ((x * y * z) == 1);
            M_XOR:   t[i] = (((x + y + z) % 2) == 1);
            M_ZERO:  t[i] = 1'b0;
            M_ONE:   t[i] = 1'b1;
            default: t[i] = lt[i];
         endcase
      end
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done pulse must correspond to a queued scan.
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (sb_tab.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_done: got done=1, expected no pending scan at %0t", $time);
         end else begin
            logic [7:0] wt;
            logic       wm;
            wt = sb_tab.pop_front();
            wm = sb_match.pop_front();
            chk("sb_table", {24'd0, table_out}, {24'd0, wt});
`ifdef SCAN_COMPARE_EN
            chk("sb_match", {31'd0, match}, {31'd0, wm});
`endif
            $display("scan done: table_out=%02h expected=%02h match=%0b", table_out, wt, match);
         end
      end
   end

   task automatic run_scan(input int md, input logic [7:0] lt, input logic [7:0] ex,
                           input bit glitchy, input bit repulse, input logic [7:0] ex_mid);
      logic [7:0] want;
      mode     = md;
      lut      = lt;
      expected = ex;
      want     = model_table(md, lt);
      sb_tab.push_back(want);
      sb_match.push_back(want == ex);
      start = 1'b1;
      tick();                       // edge T0
      start = 1'b0;
      for (int m = 0; m < 16; m++) begin
         chk("scan_abc", {29'd0, a, b, c}, m / 2);
         chk("scan_busy", {31'd0, busy}, 32'd1);
         chk("scan_done_low", {31'd0, done}, 32'd0);
         glitch = (glitchy && (m % 2 == 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
         start  = repulse && (m == 4 || m == 14);
         if (m == 6) expected = ex_mid;
         tick();                    // edge T0+m+1
      end
      glitch = 1'b0;
      start  = 1'b0;
      chk("end_done", {31'd0, done}, 32'd1);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_abc", {29'd0, a, b, c}, 32'd0);
      chk("end_table", {24'd0, table_out}, {24'd0, want});
      tick();
      chk("post_done", {31'd0, done}, 32'd0);
      tick();
      chk("post_idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = M_AND; lut = 8'h00; glitch = 1'b0; expected = 8'h00;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_abc", {29'd0, a, b, c}, 32'd0);
      chk("rst_table", {24'd0, table_out}, 32'd0);
`ifdef SCAN_COMPARE_EN
      chk("rst_match", {31'd0, match}, 32'd0);
`endif
      rst = 1'b0;
      tick();

      run_scan(M_AND,  8'h00, 8'h80, 1'b0, 1'b0, 8'h80);
      run_scan(M_XOR,  8'h00, 8'h96, 1'b0, 1'b0, 8'h96);
      run_scan(M_ZERO, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
      run_scan(M_ONE,  8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF);
      run_scan(M_AND,  8'h00, 8'h80, 1'b0, 1'b1, 8'h80);   // start re-pulsed mid-scan

      // Reset at T0+9 aborts the scan; reset also beats a simultaneous start.
      mode  = M_AND;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int m = 0; m < 8; m++) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_table", {24'd0, table_out}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_abc", {29'd0, a, b, c}, 32'd0);
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_prio_busy", {31'd0, busy}, 32'd0);
      for (int m = 0; m < 20; m++) begin
         tick();
         chk("abort_quiet", {30'd0, done, busy}, 32'd0);
      end
      run_scan(M_AND, 8'h00, 8'h80, 1'b0, 1'b0, 8'h80);

`ifdef SCAN_COMPARE_EN
      run_scan(M_AND, 8'h00, 8'h80, 1'b0, 1'b0, 8'h81);   // mid-scan change ignored
      run_scan(M_AND, 8'h00, 8'h81, 1'b0, 1'b0, 8'h81);
`endif

      for (int r = 0; r < 6; r++) begin
         logic [7:0] rl, re;
         rl = 8'($urandom);
         re = (r % 2 == 0) ? rl : 8'($urandom);
         run_scan(M_LUT, rl, re, 1'b1, 1'b0, 8'($urandom));
      end

      // Held start: done at T0+16, T0+34, and the third scan's T0+52.
      run_scan(M_XOR, 8'h00, 8'h96, 1'b0, 1'b0, 8'h96);
      mode = M_AND;
      expected = 8'h80;
      for (int k = 0; k < 3; k++) begin
         sb_tab.push_back(model_table(M_AND, 8'h00));
         sb_match.push_back(1'b1);
      end
      start = 1'b1;
      for (int cy = 0; cy < 56; cy++) begin
         tick();
         if (cy == 39) start = 1'b0;
         chk("held_done", {31'd0, done}, (cy == 16 || cy == 34 || cy == 52) ? 32'd1 : 32'd0);
         chk("held_table", {24'd0, table_out}, (cy < 16) ? 32'h96 : 32'h80);
      end

      for (int m = 0; m < 4; m++) tick();
      chk("sb_drained", sb_tab.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
